// File: rtl/rx_symbol_deframer.sv
// Byte-to-class decoder, COM alignment tracker and STP/SDP..END packet extractor; all outputs registered, 1-cycle latency.
// No backpressure: every IN_VALID byte is consumed, IN_VALID=0 cycles are ignored.
module rx_symbol_deframer #(
  parameter logic [7:0] COM     = 8'hBC,
  parameter logic [7:0] PAD     = 8'hF7,
  parameter logic [7:0] SKP     = 8'h1C,
  parameter logic [7:0] STP     = 8'hFB,
  parameter logic [7:0] SDP     = 8'h5C,
  parameter logic [7:0] END     = 8'hFD,
  parameter logic [7:0] EDB     = 8'hFE,
  parameter logic [7:0] FTS     = 8'h3C,
  parameter logic [7:0] IDL     = 8'h7C,
  parameter int         MAX_LEN = 1024,
  parameter int         LEN_W   = 11
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             IN_VALID,
  input  logic             IN_K,
  input  logic [7:0]       IN_DATA,
  output logic [3:0]       CONTROL_OUT,
  output logic             CTRL_VALID,
  output logic [7:0]       DATA_OUT,
  output logic             DATA_VALID,
  output logic             SOP,
  output logic             EOP,
  output logic             PKT_ERR,
  output logic             PKT_TYPE,
  output logic [LEN_W-1:0] PKT_LEN,
  output logic             ALIGNED
);

  localparam logic [3:0] CL_COM  = 4'd0;
  localparam logic [3:0] CL_PAD  = 4'd1;
  localparam logic [3:0] CL_SKP  = 4'd2;
  localparam logic [3:0] CL_STP  = 4'd3;
  localparam logic [3:0] CL_SDP  = 4'd4;
  localparam logic [3:0] CL_END  = 4'd5;
  localparam logic [3:0] CL_EDB  = 4'd6;
  localparam logic [3:0] CL_FTS  = 4'd7;
  localparam logic [3:0] CL_IDL  = 4'd8;
  localparam logic [3:0] CL_DATA = 4'd9;
  localparam logic [3:0] CL_BAD  = 4'd15;

  localparam logic [1:0] ST_UNALIGNED = 2'd0;
  localparam logic [1:0] ST_IDLE      = 2'd1;
  localparam logic [1:0] ST_PKT       = 2'd2;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]       state;
  logic [LEN_W-1:0] count;
  logic             sop_armed;
  logic [3:0]       cls;

  always_comb begin
    cls = CL_BAD;
    if (!IN_K)                cls = CL_DATA;
    else if (IN_DATA == COM)  cls = CL_COM;
    else if (IN_DATA == PAD)  cls = CL_PAD;
    else if (IN_DATA == SKP)  cls = CL_SKP;
    else if (IN_DATA == STP)  cls = CL_STP;
    else if (IN_DATA == SDP)  cls = CL_SDP;
    else if (IN_DATA == END)  cls = CL_END;
    else if (IN_DATA == EDB)  cls = CL_EDB;
    else if (IN_DATA == FTS)  cls = CL_FTS;
    else if (IN_DATA == IDL)  cls = CL_IDL;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= ST_UNALIGNED;
      count       <= '0;
      sop_armed   <= 1'b0;
      CONTROL_OUT <= 4'd0;
      CTRL_VALID  <= 1'b0;
      DATA_OUT    <= 8'd0;
      DATA_VALID  <= 1'b0;
      SOP         <= 1'b0;
      EOP         <= 1'b0;
      PKT_ERR     <= 1'b0;
      PKT_TYPE    <= 1'b0;
      PKT_LEN     <= '0;
      ALIGNED     <= 1'b0;
    end else begin
      CTRL_VALID <= IN_VALID;
      DATA_VALID <= 1'b0;
      SOP        <= 1'b0;
      EOP        <= 1'b0;
      PKT_ERR    <= 1'b0;
      if (IN_VALID) begin
        CONTROL_OUT <= cls;
        if (cls == CL_BAD) begin
          // An unknown K code means we have lost symbol lock; drop any open packet.
          state     <= ST_UNALIGNED;
          ALIGNED   <= 1'b0;
          sop_armed <= 1'b0;
          if (state == ST_PKT) begin
            PKT_ERR <= 1'b1;
            PKT_LEN <= count;
          end
        end else begin
          case (state)
            ST_UNALIGNED: begin
              if (cls == CL_COM) begin
                state   <= ST_IDLE;
                ALIGNED <= 1'b1;
              end
            end
            ST_IDLE: begin
              if (cls == CL_STP || cls == CL_SDP) begin
                state     <= ST_PKT;
                PKT_TYPE  <= (cls == CL_SDP);
                count     <= '0;
                sop_armed <= 1'b1;
              end
            end
            ST_PKT: begin
              case (cls)
                CL_DATA: begin
                  if (count == LEN_MAX) begin
                    PKT_ERR <= 1'b1;
                    PKT_LEN <= LEN_MAX;
                    state   <= ST_IDLE;
                  end else begin
                    DATA_OUT   <= IN_DATA;
                    DATA_VALID <= 1'b1;
                    SOP        <= sop_armed;
                    sop_armed  <= 1'b0;
                    count      <= count + LEN_ONE;
                  end
                end
                CL_END: begin
                  EOP     <= 1'b1;
                  PKT_LEN <= count;
                  state   <= ST_IDLE;
                end
                CL_PAD, CL_SKP: begin
                end
                CL_STP, CL_SDP: begin
                  // Abort the current packet and open the new one in the same cycle.
                  PKT_ERR   <= 1'b1;
                  PKT_LEN   <= count;
                  PKT_TYPE  <= (cls == CL_SDP);
                  count     <= '0;
                  sop_armed <= 1'b1;
                end
                default: begin
                  PKT_ERR <= 1'b1;
                  PKT_LEN <= count;
                  state   <= ST_IDLE;
                end
              endcase
            end
            default: state <= ST_UNALIGNED;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_symbol_deframer.sv
// Bench for rx_symbol_deframer: directed vector table, hand sequences, and random traffic against a queue-based model.
module tb_rx_symbol_deframer;
  localparam int TB_MAX = 4;
  localparam int LW = 11;
  localparam logic [7:0] SYM [0:8] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic IN_VALID = 1'b0, IN_K = 1'b0;
  logic [7:0] IN_DATA = 8'd0;
  logic [3:0] CONTROL_OUT;
  logic CTRL_VALID, DATA_VALID, SOP, EOP, PKT_ERR, PKT_TYPE, ALIGNED;
  logic [7:0] DATA_OUT;
  logic [LW-1:0] PKT_LEN;

  int n_chk = 0;
  int n_fail = 0;

  rx_symbol_deframer #(.MAX_LEN(TB_MAX), .LEN_W(LW)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_K(IN_K), .IN_DATA(IN_DATA),
    .CONTROL_OUT(CONTROL_OUT), .CTRL_VALID(CTRL_VALID), .DATA_OUT(DATA_OUT),
    .DATA_VALID(DATA_VALID), .SOP(SOP), .EOP(EOP), .PKT_ERR(PKT_ERR),
    .PKT_TYPE(PKT_TYPE), .PKT_LEN(PKT_LEN), .ALIGNED(ALIGNED)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic       m_aligned, m_open, m_type;
  logic [7:0] m_q [$];
  logic [3:0] e_ctrl;
  logic       e_cv, e_dv, e_sop, e_eop, e_err;
  logic [7:0] e_dout;
  int         e_len;

  function automatic int decode(input logic k, input logic [7:0] d);
    if (!k) return 9;
    for (int i = 0; i < 9; i++) if (d == SYM[i]) return i;
    return 15;
  endfunction

  task automatic m_reset();
    m_aligned = 0; m_open = 0; m_type = 0; m_q.delete();
    e_ctrl = 0; e_cv = 0; e_dv = 0; e_sop = 0; e_eop = 0; e_err = 0; e_dout = 0; e_len = 0;
  endtask

  task automatic close_pkt(input logic clean, input int len);
    if (clean) e_eop = 1; else e_err = 1;
    e_len = len;
    m_open = 0;
  endtask

  task automatic m_step(input logic v, input logic k, input logic [7:0] d);
    int c;
    e_cv = v; e_dv = 0; e_sop = 0; e_eop = 0; e_err = 0;
    if (!v) return;
    c = decode(k, d);
    e_ctrl = 4'(c);
    if (c == 15) begin
      if (m_open) close_pkt(0, m_q.size());
      m_open = 0; m_aligned = 0;
      return;
    end
    if (!m_aligned) begin
      if (c == 0) m_aligned = 1;
      return;
    end
    if (!m_open) begin
      if (c == 3 || c == 4) begin
        m_open = 1; m_type = (c == 4); m_q.delete();
      end
      return;
    end
    case (c)
      9: begin
        if (m_q.size() == TB_MAX) close_pkt(0, TB_MAX);
        else begin
          e_dv = 1; e_dout = d; e_sop = (m_q.size() == 0); m_q.push_back(d);
        end
      end
      5: close_pkt(1, m_q.size());
      1, 2: ;
      3, 4: begin
        close_pkt(0, m_q.size());
        m_open = 1; m_type = (c == 4); m_q.delete();
      end
      default: close_pkt(0, m_q.size());
    endcase
  endtask

  task automatic compare_all(input string tag);
    chk({tag, " ctrl"}, 32'(CONTROL_OUT), 32'(e_ctrl));
    chk({tag, " cv"}, 32'(CTRL_VALID), 32'(e_cv));
    chk({tag, " dout"}, 32'(DATA_OUT), 32'(e_dout));
    chk({tag, " dv"}, 32'(DATA_VALID), 32'(e_dv));
    chk({tag, " sop"}, 32'(SOP), 32'(e_sop));
    chk({tag, " eop"}, 32'(EOP), 32'(e_eop));
    chk({tag, " err"}, 32'(PKT_ERR), 32'(e_err));
    chk({tag, " type"}, 32'(PKT_TYPE), 32'(m_type));
    chk({tag, " len"}, 32'(PKT_LEN), 32'(e_len));
    chk({tag, " aligned"}, 32'(ALIGNED), 32'(m_aligned));
  endtask

  task automatic step(input string tag, input logic v, input logic k, input logic [7:0] d);
    IN_VALID = v; IN_K = k; IN_DATA = d;
    m_step(v, k, d);
    @(posedge CLK); #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    RESET = 1; IN_VALID = 0; IN_K = 0; IN_DATA = 0;
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    compare_all("reset");
    RESET = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic v, k; logic [7:0] d;
    logic [3:0] ctrl; logic dv; logic [7:0] dout;
    logic sop, eop, err; int len; logic typ, al;
  } vec_t;
  vec_t tv [$];

  task automatic add(input logic v, k, input logic [7:0] d, input logic [3:0] ctrl,
                     input logic dv, input logic [7:0] dout, input logic sop, eop, err,
                     input int len, input logic typ, al);
    vec_t x;
    x.v = v; x.k = k; x.d = d; x.ctrl = ctrl; x.dv = dv; x.dout = dout;
    x.sop = sop; x.eop = eop; x.err = err; x.len = len; x.typ = typ; x.al = al;
    tv.push_back(x);
  endtask

  initial begin
    // test 1: clean STP packet
    add(1,1,8'hBC, 0, 0,8'h00,0,0,0,0, 0,1);
    add(1,1,8'hFB, 3, 0,8'h00,0,0,0,0, 0,1);
    add(1,0,8'h11, 9, 1,8'h11,1,0,0,0, 0,1);
    add(1,0,8'h22, 9, 1,8'h22,0,0,0,0, 0,1);
    add(1,0,8'h33, 9, 1,8'h33,0,0,0,0, 0,1);
    add(1,1,8'hFD, 5, 0,8'h00,0,1,0,3, 0,1);
    // test 3: SDP packet with SKP/PAD, aborted by EDB
    add(1,1,8'hBC, 0, 0,8'h00,0,0,0,0, 0,1);
    add(1,1,8'h5C, 4, 0,8'h00,0,0,0,0, 1,1);
    add(1,0,8'h01, 9, 1,8'h01,1,0,0,0, 1,1);
    add(1,1,8'h1C, 2, 0,8'h00,0,0,0,0, 1,1);
    add(1,1,8'hF7, 1, 0,8'h00,0,0,0,0, 1,1);
    add(0,0,8'h00, 0, 0,8'h00,0,0,0,0, 1,1);
    add(1,0,8'h02, 9, 1,8'h02,0,0,0,0, 1,1);
    add(1,1,8'hFE, 6, 0,8'h00,0,0,1,2, 1,1);
    // test 4: overflow at MAX_LEN=4, then END with nothing open
    add(1,1,8'hBC, 0, 0,8'h00,0,0,0,0, 1,1);
    add(1,1,8'hFB, 3, 0,8'h00,0,0,0,0, 0,1);
    add(1,0,8'hA1, 9, 1,8'hA1,1,0,0,0, 0,1);
    add(1,0,8'hA2, 9, 1,8'hA2,0,0,0,0, 0,1);
    add(1,0,8'hA3, 9, 1,8'hA3,0,0,0,0, 0,1);
    add(1,0,8'hA4, 9, 1,8'hA4,0,0,0,0, 0,1);
    add(1,0,8'hA5, 9, 0,8'h00,0,0,1,4, 0,1);
    add(1,1,8'hFD, 5, 0,8'h00,0,0,0,0, 0,1);
    // test 5: STP inside a packet, then bad K while idle
    add(1,1,8'hBC, 0, 0,8'h00,0,0,0,0, 0,1);
    add(1,1,8'hFB, 3, 0,8'h00,0,0,0,0, 0,1);
    add(1,0,8'h10, 9, 1,8'h10,1,0,0,0, 0,1);
    add(1,1,8'hFB, 3, 0,8'h00,0,0,1,1, 0,1);
    add(1,0,8'h20, 9, 1,8'h20,1,0,0,0, 0,1);
    add(1,1,8'hFD, 5, 0,8'h00,0,1,0,1, 0,1);
    add(1,1,8'h00,15, 0,8'h00,0,0,0,0, 0,0);
    // test 2: framing ignored while unaligned
    add(1,1,8'hFB, 3, 0,8'h00,0,0,0,0, 0,0);
    add(1,0,8'hAA, 9, 0,8'h00,0,0,0,0, 0,0);
    add(1,1,8'hFD, 5, 0,8'h00,0,0,0,0, 0,0);
    add(0,0,8'h00, 0, 0,8'h00,0,0,0,0, 0,0);
    // bad K inside a packet aborts it
    add(1,1,8'hBC, 0, 0,8'h00,0,0,0,0, 0,1);
    add(1,1,8'hFB, 3, 0,8'h00,0,0,0,0, 0,1);
    add(1,0,8'h77, 9, 1,8'h77,1,0,0,0, 0,1);
    add(1,1,8'h00,15, 0,8'h00,0,0,1,1, 0,0);

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      IN_VALID = tv[i].v; IN_K = tv[i].k; IN_DATA = tv[i].d;
      @(posedge CLK); #1;
      chk({t, " cv"}, 32'(CTRL_VALID), 32'(tv[i].v));
      if (tv[i].v) chk({t, " ctrl"}, 32'(CONTROL_OUT), 32'(tv[i].ctrl));
      chk({t, " dv"}, 32'(DATA_VALID), 32'(tv[i].dv));
      if (tv[i].dv) chk({t, " dout"}, 32'(DATA_OUT), 32'(tv[i].dout));
      chk({t, " sop"}, 32'(SOP), 32'(tv[i].sop));
      chk({t, " eop"}, 32'(EOP), 32'(tv[i].eop));
      chk({t, " err"}, 32'(PKT_ERR), 32'(tv[i].err));
      if (tv[i].eop || tv[i].err) chk({t, " len"}, 32'(PKT_LEN), 32'(tv[i].len));
      chk({t, " type"}, 32'(PKT_TYPE), 32'(tv[i].typ));
      chk({t, " aligned"}, 32'(ALIGNED), 32'(tv[i].al));
    end

    // test 6: test 1 with IN_VALID gaps, then reset mid-packet
    do_reset();
    step("t6 com", 1, 1, 8'hBC); step("t6 gap", 0, 0, 8'h00);
    step("t6 stp", 1, 1, 8'hFB); step("t6 gap", 0, 0, 8'h00);
    step("t6 d11", 1, 0, 8'h11); step("t6 gap", 0, 1, 8'hFD);
    step("t6 d22", 1, 0, 8'h22); step("t6 gap", 0, 0, 8'h00);
    step("t6 d33", 1, 0, 8'h33); step("t6 gap", 0, 0, 8'h00);
    step("t6 end", 1, 1, 8'hFD);
    chk("t6 eop direct", 32'(EOP), 32'd1);
    chk("t6 len direct", 32'(PKT_LEN), 32'd3);
    step("t6 stp2", 1, 1, 8'h5C);
    step("t6 d55", 1, 0, 8'h55);
    RESET = 1;
    #2;
    m_reset();
    compare_all("t6 async reset");
    @(posedge CLK); #1;
    RESET = 0;
    compare_all("t6 after reset");
    step("t6 end unaligned", 1, 1, 8'hFD);
    chk("t6 aligned direct", 32'(ALIGNED), 32'd0);

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic v, k;
      logic [7:0] d;
      v = ($urandom_range(0, 9) < 8);
      r = $urandom_range(0, 99);
      if (r < 58) begin k = 0; d = 8'($urandom); end
      else if (r < 98) begin k = 1; d = SYM[$urandom_range(0, 8)]; end
      else begin k = 1; d = 8'h00; end
      step("rand", v, k, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
